can_bit_timing_sample: RTL and testbench
========================================

CAN_BIT_TIMING_SAMPLE -- requirements
Module: can_bit_timing_sample

Interface
REQ-001 Parameter CLK_MHZ, default 100, system clock frequency in MHz.
REQ-002 Parameter BITRATE_KBPS, default 1000, CAN bit rate in kbit/s.
REQ-003 Parameter SAMPLE_PCT, default 75, sample point as percent of bit time; legal range 50..90.
REQ-004 Parameter SJW_CLKS, default 4, maximum resynchronisation jump in clocks; legal range 1..BIT_CLKS/4.
REQ-005 Parameter TRIPLE_SAMPLE, default 0, 1 selects 3-point majority sampling.
REQ-006 Parameter DESTUFF, default 1, 1 enables stuff-bit removal and checking.
REQ-007 clk  input  1  system clock; all logic on rising edge.
REQ-008 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-009 en  input  1  sampling enable; low forces IDLE.
REQ-010 din  input  1  raw CAN RX line (1 = recessive); asynchronous to clk.
REQ-011 dout  output  1  sampled (destuffed) bit value.
REQ-012 dvalid  output  1  one-cycle strobe; dout is valid while high.
REQ-013 stuff_err  output  1  one-cycle strobe on stuff violation.
REQ-014 busy  output  1  high while in RUN state.

Function
REQ-015 BIT_CLKS = CLK_MHZ*1000/BITRATE_KBPS and SAMPLE_CLK = BIT_CLKS*SAMPLE_PCT/100 (integer division) shall be elaboration constants; defaults give 100 and 75.
REQ-016 din shall pass a 2-flop synchroniser (din_s); all edge and sample logic uses din_s only.
REQ-017 Falling edge = din_s 0 with previous din_s 1.
REQ-018 States IDLE and RUN; bit counter width ceil(log2(BIT_CLKS)) counts 0..BIT_CLKS-1 and wraps to 0 in RUN.
REQ-019 IDLE -> RUN on a falling edge while en=1 (hard sync): the counter is 0 in the edge cycle t0, and run tracking is cleared.
REQ-020 Any state -> IDLE in the cycle after en=0 is seen; the counter and run tracking are cleared, and no dvalid is produced from that cycle on.
REQ-021 Single sample: the bit value is din_s at counter==SAMPLE_CLK.
REQ-022 Triple sample: the bit value is the majority of din_s at counters SAMPLE_CLK-2, SAMPLE_CLK-1 and SAMPLE_CLK.
REQ-023 Sample latency: dout/dvalid are registered and appear one cycle after the counter==SAMPLE_CLK cycle, so the first dvalid is at t0+SAMPLE_CLK+1.
REQ-024 Resync (RUN only): a falling edge at counter c is used only if the last sampled bit was 1 and no resync has occurred yet in this bit; c==0 gives no adjustment.
REQ-025 Late edge (0<c<=SAMPLE_CLK): next counter = c+1-min(c,SJW_CLKS).
REQ-026 Early edge (c>SAMPLE_CLK): next counter = (c+1+min(BIT_CLKS-c,SJW_CLKS)) mod BIT_CLKS; a sample already taken in that bit is not repeated.
REQ-027 Destuff (DESTUFF=1): track the last bit value and a run count (3 bits); after 5 equal consecutive sampled bits, the next sampled bit is a stuff bit.
REQ-028 If the stuff bit differs from the run, it is dropped (no dvalid) and the run restarts at 1 with the new value.
REQ-029 If the stuff bit equals the run, stuff_err pulses for 1 cycle at the would-be dvalid cycle, no dvalid is produced, and the state goes to IDLE.
REQ-030 DESTUFF=0: every sampled bit produces dvalid; stuff_err stays 0.
REQ-031 busy = (state==RUN), registered.

Reset
REQ-032 rst_n=0: state IDLE, counter 0, synchroniser flops 1, dout=1, dvalid=0, stuff_err=0, busy=0, run count 0, last bit 1.
REQ-033 Release of rst_n mid-frame: the block stays in IDLE until a new falling edge with en=1.

Verification
REQ-034 Reset asserted mid-bit -> all outputs at reset values asynchronously; no dvalid until a new hard sync.
REQ-035 Defaults, en=1, din 1->0 -> busy rises, first dvalid at t0+76 with dout=0, then dvalid every 100 cycles.
REQ-036 Frame with one recessive->dominant edge delayed 3 clocks -> subsequent dvalid delayed 3 clocks; with a 9-clock delay -> subsequent dvalid delayed 4 clocks (SJW clamp).
REQ-037 DESTUFF=1, bits 0,0,0,0,0,1,0 -> 6 dvalids with values 0,0,0,0,0,0 (the 1 is dropped); bits 0 x6 -> 5 dvalids, stuff_err pulse, then busy=0.
REQ-038 TRIPLE_SAMPLE=1, 1-cycle din_s glitch at counter 74 during a 0 bit -> dout=0; TRIPLE_SAMPLE=0 with the glitch at counter 75 -> dout=1.
REQ-039 en dropped at counter 50 -> busy=0 next cycle, no further dvalid; en re-raised -> block waits for the next falling edge.

Source files
------------

// File: rtl/can_bit_timing_sample.sv
// CAN receive bit timing: synchronises the raw RX line, hard-syncs on the
// first falling edge, resynchronises within the SJW limit, samples each bit
// (single or 3-point majority) and optionally removes and checks stuff bits.
module can_bit_timing_sample #(
  parameter int CLK_MHZ       = 100,
  parameter int BITRATE_KBPS  = 1000,
  parameter int SAMPLE_PCT    = 75,
  parameter int SJW_CLKS      = 4,
  parameter int TRIPLE_SAMPLE = 0,
  parameter int DESTUFF       = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  output logic dout,
  output logic dvalid,
  output logic stuff_err,
  output logic busy
);

  localparam int BIT_CLKS   = CLK_MHZ * 1000 / BITRATE_KBPS;
  localparam int SAMPLE_CLK = BIT_CLKS * SAMPLE_PCT / 100;
  localparam int CNT_W      = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

  localparam logic [CNT_W-1:0] SAMPLE_C = CNT_W'(SAMPLE_CLK);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [CNT_W:0]   BIT_E    = (CNT_W + 1)'(BIT_CLKS);
  localparam logic [CNT_W:0]   SJW_E    = (CNT_W + 1)'(SJW_CLKS);
  localparam logic [CNT_W:0]   ONE_E    = (CNT_W + 1)'(1);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_RUN  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic             din_p0;
  logic             din_s;
  logic             din_s_p1;
  logic             din_s_p2;
  logic             state;
  logic [CNT_W-1:0] cnt;
  logic             resynced;
  logic             sampled;
  logic [2:0]       run_cnt;
  logic             last_bit;

  logic             din_fall;
  logic             do_resync;
  logic             resync_wrap;
  logic             new_bit;
  logic             take_sample;
  logic             bit_val;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W:0]   cnt_ext;
  logic [CNT_W:0]   jump;
  logic [CNT_W:0]   sum;

  assign din_fall    = ~din_s & din_s_p1;
  assign take_sample = (state == STATE_RUN) && (cnt == SAMPLE_C) && !sampled;
  assign bit_val     = (TRIPLE_SAMPLE != 0) ? maj3(din_s_p2, din_s_p1, din_s) : din_s;

  // Two-flop synchroniser plus the history taps used for edge and majority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_p0   <= 1'b1;
      din_s    <= 1'b1;
      din_s_p1 <= 1'b1;
      din_s_p2 <= 1'b1;
    end else begin
      din_p0   <= din;
      din_s    <= din_p0;
      din_s_p1 <= din_s;
      din_s_p2 <= din_s_p1;
    end
  end

  // Next bit-counter value, including SJW-limited late/early resync
  always_comb begin
    cnt_ext     = {1'b0, cnt};
    jump        = '0;
    sum         = '0;
    resync_wrap = 1'b0;
    do_resync   = din_fall && last_bit && !resynced && (cnt != '0);
    cnt_nxt     = (cnt == LAST_C) ? '0 : cnt + ONE_C;
    if (do_resync) begin
      if (cnt <= SAMPLE_C) begin
        jump = (cnt_ext < SJW_E) ? cnt_ext : SJW_E;
        sum  = cnt_ext + ONE_E - jump;
      end else begin
        jump = ((BIT_E - cnt_ext) < SJW_E) ? (BIT_E - cnt_ext) : SJW_E;
        sum  = cnt_ext + ONE_E + jump;
        if (sum >= BIT_E) begin
          sum         = sum - BIT_E;
          resync_wrap = 1'b1;
        end
      end
      cnt_nxt = sum[CNT_W-1:0];
    end
    new_bit = resync_wrap || (!do_resync && (cnt == LAST_C));
  end

  // Control state, bit timing, sampling and destuffing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= STATE_IDLE;
      busy      <= 1'b0;
      cnt       <= '0;
      resynced  <= 1'b0;
      sampled   <= 1'b0;
      run_cnt   <= '0;
      last_bit  <= 1'b1;
      dout      <= 1'b1;
      dvalid    <= 1'b0;
      stuff_err <= 1'b0;
    end else begin
      dvalid    <= 1'b0;
      stuff_err <= 1'b0;
      if (!en) begin
        state    <= STATE_IDLE;
        busy     <= 1'b0;
        cnt      <= '0;
        resynced <= 1'b0;
        sampled  <= 1'b0;
        run_cnt  <= '0;
        last_bit <= 1'b1;
      end else if (state == STATE_IDLE) begin
        if (din_fall) begin
          state    <= STATE_RUN;
          busy     <= 1'b1;
          cnt      <= ONE_C;
          resynced <= 1'b0;
          sampled  <= 1'b0;
          run_cnt  <= '0;
          last_bit <= 1'b1;
        end
      end else begin
        cnt <= cnt_nxt;
        if (do_resync) resynced <= !resync_wrap;
        else if (new_bit) resynced <= 1'b0;
        if (new_bit) sampled <= 1'b0;
        else if (take_sample) sampled <= 1'b1;
        if (take_sample) begin
          if ((DESTUFF != 0) && (run_cnt == 3'd5)) begin
            if (bit_val != last_bit) begin
              run_cnt  <= 3'd1;
              last_bit <= bit_val;
            end else begin
              stuff_err <= 1'b1;
              state     <= STATE_IDLE;
              busy      <= 1'b0;
              cnt       <= '0;
              resynced  <= 1'b0;
              sampled   <= 1'b0;
              run_cnt   <= '0;
              last_bit  <= 1'b1;
            end
          end else begin
            dvalid   <= 1'b1;
            dout     <= bit_val;
            last_bit <= bit_val;
            if ((run_cnt == '0) || (bit_val != last_bit)) run_cnt <= 3'd1;
            else if (run_cnt != 3'd7) run_cnt <= run_cnt + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_can_bit_timing_sample.sv
// Directed bench for can_bit_timing_sample: hard sync, sample latency,
// SJW resync, destuffing, triple sampling, enable and reset behaviour.
module tb_can_bit_timing_sample;

  logic clk, rst_n, en, din;
  logic dout_def, dvalid_def, serr_def, busy_def;
  logic dout_tri, dvalid_tri, serr_tri, busy_tri;
  logic dout_nds, dvalid_nds, serr_nds, busy_nds;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  int   def_cnt, def_off, tri_cnt, nds_cnt, def_err, def_err_off, tri_err, nds_err;
  logic def_val, tri_val, nds_val, def_busy2, def_busy3, def_busy_end, nds_busy_end;

  can_bit_timing_sample u_def (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din),
    .dout(dout_def), .dvalid(dvalid_def), .stuff_err(serr_def), .busy(busy_def));

  can_bit_timing_sample #(.TRIPLE_SAMPLE(1)) u_tri (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din),
    .dout(dout_tri), .dvalid(dvalid_tri), .stuff_err(serr_tri), .busy(busy_tri));

  can_bit_timing_sample #(.DESTUFF(0)) u_nds (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din),
    .dout(dout_nds), .dvalid(dvalid_nds), .stuff_err(serr_nds), .busy(busy_nds));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    def_cnt = 0; def_off = -1; tri_cnt = 0; nds_cnt = 0;
    def_err = 0; def_err_off = -1; tri_err = 0; nds_err = 0;
    def_val = 1'bx; tri_val = 1'bx; nds_val = 1'bx;
    def_busy2 = 1'bx; def_busy3 = 1'bx; def_busy_end = 1'bx; nds_busy_end = 1'bx;
  endtask

  task automatic observe(input int off);
    if (dvalid_def) begin
      if (def_cnt == 0) begin def_off = off; def_val = dout_def; end
      def_cnt++;
    end
    if (dvalid_tri) begin
      if (tri_cnt == 0) tri_val = dout_tri;
      tri_cnt++;
    end
    if (dvalid_nds) begin
      if (nds_cnt == 0) nds_val = dout_nds;
      nds_cnt++;
    end
    if (serr_def) begin
      if (def_err == 0) def_err_off = off;
      def_err++;
    end
    if (serr_tri) tri_err++;
    if (serr_nds) nds_err++;
    if (off == 2) def_busy2 = busy_def;
    if (off == 3) def_busy3 = busy_def;
    def_busy_end = busy_def;
    nds_busy_end = busy_nds;
  endtask

  task automatic watch(input int n);
    clear_obs();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      observe(-1);
    end
  endtask

  // Holds the old level for pre cycles, then drives bit b for len cycles
  // with an optional one-cycle inverted glitch at offset glitch.
  task automatic bit_cycle(input logic b, input int pre, input int len, input int glitch);
    clear_obs();
    for (int i = 0; i < pre; i++) begin
      @(negedge clk);
      observe(-1);
    end
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      observe(j);
      if (j == 0 || j == glitch + 1) din = b;
      if (j == glitch) din = ~b;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; din = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dout", dout_def, 1);
    check("rst_dvalid", dvalid_def, 0);
    check("rst_stuff_err", serr_def, 0);
    check("rst_busy", busy_def, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (5) @(negedge clk);

    // Frame 1: SOF and dominant run, stuff bit, resync, glitches
    bit_cycle(1'b0, 0, 100, -1);
    check("sof_busy_t1", def_busy2, 0);
    check("sof_busy_t2", def_busy3, 1);
    check("sof_dv_offset", def_off, 78);
    check("sof_dout", def_val, 0);
    check("sof_dv_count", def_cnt, 1);
    for (int i = 1; i < 5; i++) begin
      bit_cycle(1'b0, 0, 100, -1);
      check("run0_dv_offset", def_off, 78);
      check("run0_dout", def_val, 0);
    end
    bit_cycle(1'b1, 0, 100, -1);
    check("stuff_drop_dv", def_cnt, 0);
    check("stuff_drop_err", def_err, 0);
    check("nodestuff_dv", nds_cnt, 1);
    check("nodestuff_dout", nds_val, 1);
    bit_cycle(1'b0, 0, 100, -1);
    check("after_stuff_dout", def_val, 0);
    check("after_stuff_offset", def_off, 78);
    bit_cycle(1'b1, 0, 100, -1);
    check("rec_dout", def_val, 1);
    bit_cycle(1'b0, 3, 100, -1);
    check("resync3_offset", def_off, 78);
    check("resync3_dout", def_val, 0);
    bit_cycle(1'b1, 0, 100, -1);
    check("post_resync3_offset", def_off, 78);
    bit_cycle(1'b0, 9, 95, -1);
    check("resync9_offset", def_off, 73);
    bit_cycle(1'b1, 0, 100, -1);
    check("post_resync9_offset", def_off, 78);
    bit_cycle(1'b0, 0, 100, -1);
    check("pre_glitch_dout", def_val, 0);
    bit_cycle(1'b0, 0, 100, 74);
    check("glitch74_triple", tri_val, 0);
    check("glitch74_single", def_val, 0);
    bit_cycle(1'b0, 0, 100, 75);
    check("glitch75_single", def_val, 1);
    check("glitch75_triple", tri_val, 0);
    check("glitch75_nodestuff", nds_val, 1);
    en = 1'b0; din = 1'b1;
    repeat (3) @(negedge clk);
    check("f1_end_busy", busy_def, 0);
    repeat (10) @(negedge clk);

    // Frame 2: six dominant bits give a stuff error
    en = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bit_cycle(1'b0, 0, 100, -1);
      check("f2_dout", def_val, 0);
    end
    bit_cycle(1'b0, 0, 100, -1);
    check("serr_no_dv", def_cnt, 0);
    check("serr_count", def_err, 1);
    check("serr_offset", def_err_off, 78);
    check("serr_busy", def_busy_end, 0);
    check("serr_triple", tri_err, 1);
    check("nodestuff_6th_dv", nds_cnt, 1);
    check("nodestuff_no_err", nds_err, 0);
    check("nodestuff_busy", nds_busy_end, 1);
    din = 1'b1; en = 1'b0;
    repeat (10) @(negedge clk);

    // Frame 3: enable dropped mid-bit, re-armed, then async reset mid-bit
    en = 1'b1;
    repeat (10) @(negedge clk);
    @(negedge clk);
    din = 1'b0;
    repeat (52) @(negedge clk);
    check("en_busy_before", busy_def, 1);
    en = 1'b0;
    @(negedge clk);
    check("en_drop_busy", busy_def, 0);
    watch(150);
    check("en_drop_no_dv", def_cnt, 0);
    en = 1'b1;
    watch(150);
    check("en_rearm_no_dv", def_cnt, 0);
    check("en_rearm_idle", def_busy_end, 0);
    din = 1'b1;
    repeat (10) @(negedge clk);
    bit_cycle(1'b0, 0, 100, -1);
    check("rearm_sync_offset", def_off, 78);
    check("rearm_sync_busy", def_busy_end, 1);
    repeat (40) @(negedge clk);
    check("pre_rst_dout", dout_def, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dout", dout_def, 1);
    check("async_rst_busy", busy_def, 0);
    check("async_rst_dvalid", dvalid_def, 0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    en = 1'b1;
    watch(200);
    check("post_rst_no_dv", def_cnt, 0);
    check("post_rst_idle", def_busy_end, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
